// File: rtl/counter_pkg.sv
// Shared direction and mode encodings for the up/down counter family.
package counter_pkg;

  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/updown_counter_next.sv
// Pure combinational next-count arithmetic, done in W+1 bits so that
// count+step and limit+1 never overflow.
module updown_counter_next
  import counter_pkg::*;
#(
  parameter int W = 8,
  parameter int S = 4
) (
  input  logic [W-1:0] count,
  input  logic [W-1:0] limit,
  input  logic [S-1:0] step,
  input  logic         dir,
  input  logic         sat,
  output logic [W-1:0] next_count,
  output logic         cross_up,
  output logic         cross_dn
);

  logic [W:0] cnt_x;
  logic [W:0] lim_x;
  logic [W:0] lim1;
  logic [W:0] step_x;
  logic [W:0] s_eff;
  logic [W:0] sum;
  logic [W:0] res;

  always_comb begin
    cnt_x  = {1'b0, count};
    lim_x  = {1'b0, limit};
    lim1   = lim_x + {{W{1'b0}}, 1'b1};
    step_x = {{(W+1-S){1'b0}}, step};
    s_eff  = (step_x > lim1) ? lim1 : step_x;
    sum    = cnt_x + s_eff;

    res      = cnt_x;
    cross_up = 1'b0;
    cross_dn = 1'b0;

    if (s_eff == '0) begin
      res = cnt_x;
    end else if (cnt_x > lim_x) begin
      // Limit was lowered under the count: always a crossing back into range.
      if (dir == DIR_UP) begin
        cross_up = 1'b1;
        res      = (sat == MODE_SAT) ? lim_x : '0;
      end else begin
        cross_dn = 1'b1;
        res      = lim_x;
      end
    end else if (dir == DIR_UP) begin
      if (sum <= lim_x) begin
        res = sum;
      end else begin
        cross_up = 1'b1;
        res      = (sat == MODE_SAT) ? lim_x : (sum - lim1);
      end
    end else begin
      if (s_eff <= cnt_x) begin
        res = cnt_x - s_eff;
      end else begin
        cross_dn = 1'b1;
        res      = (sat == MODE_SAT) ? '0 : (cnt_x + lim1 - s_eff);
      end
    end

    next_count = res[W-1:0];
  end

endmodule

// File: rtl/updown_counter.sv
// W-bit up/down counter with programmable limit and step, wrap/saturate,
// registered terminal-count pulse and sticky overflow/underflow flags.
module updown_counter #(
  parameter int W = 8,
  parameter int S = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] limit,
  input  logic [S-1:0] step,
  input  logic         sat,
  input  logic         flag_clr,
  output logic [W-1:0] count,
  output logic         tc,
  output logic         ovf,
  output logic         unf
);

  logic [W-1:0] count_q, count_d;
  logic         tc_q, tc_d;
  logic         ovf_q, ovf_d;
  logic         unf_q, unf_d;

  logic [W-1:0] next_count;
  logic         cross_up;
  logic         cross_dn;

  updown_counter_next #(.W(W), .S(S)) u_next (
    .count      (count_q),
    .limit      (limit),
    .step       (step),
    .dir        (dir),
    .sat        (sat),
    .next_count (next_count),
    .cross_up   (cross_up),
    .cross_dn   (cross_dn)
  );

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    unf_d   = unf_q;

    // flag_clr goes first so that a crossing on the same edge sets the flag.
    if (flag_clr) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end

    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
    end else if (load) begin
      count_d = (load_val > limit) ? limit : load_val;
    end else if (en) begin
      count_d = next_count;
      tc_d    = cross_up | cross_dn;
      if (cross_up) ovf_d = 1'b1;
      if (cross_dn) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule
